// File: rtl/ufm_read_ctrl.sv
// ufm_read_ctrl: word-read sequencer for the MAX 10 UFM serial port.
// Loads or increments the flash address register, latches the data register,
// then shifts out 32 bits LSB first and reports them with a one-cycle done.
module ufm_read_ctrl #(
    parameter int CLK_DIV  = 4,
    parameter int ADDR_W   = 23,
    parameter int WADDR_W  = 12,
    parameter int MAX_ADDR = 3071,
    parameter int ADDR_OFS = 512
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               rd,
    input  logic [WADDR_W-1:0] address,
    output logic               busy,
    output logic               done,
    output logic [31:0]        dout,
    output logic               err,
    output logic               arclk,
    output logic               arshft,
    output logic               ardin,
    output logic               drclk,
    output logic               drshft,
    output logic               drdin,
    input  logic               drdout
);

    localparam int CW = $clog2(2 * CLK_DIV);
    localparam int PW = $clog2(ADDR_W > 32 ? ADDR_W : 32);
    localparam logic [CW-1:0] LP_CNT_LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] LP_CNT_HI   = CW'(CLK_DIV);
    localparam logic [CW-1:0] LP_CNT_SMP  = CW'(CLK_DIV - 1);
    localparam logic [31:0]   LP_MAX      = MAX_ADDR;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_INC, S_LATCH, S_SHIFT, S_DONE
    } state_t;

    state_t               r_state, w_state;
    logic [CW-1:0]        r_cnt, w_cnt;
    logic [PW-1:0]        r_pcnt, w_pcnt, w_npulse_m1;
    logic [ADDR_W-1:0]    r_sreg, w_sreg;
    logic [WADDR_W-1:0]   r_addr, w_addr, r_last, w_last;
    logic                 r_last_valid, w_last_valid;
    logic [31:0]          r_data, w_data, r_dout, w_dout;
    logic                 r_err, w_err;
    logic                 r_busy, w_busy, r_done, w_done;
    logic                 r_arclk, w_arclk, r_arshft, w_arshft, r_ardin, w_ardin;
    logic                 r_drclk, w_drclk, r_drshft, w_drshft;
    logic                 w_pulse_end, w_seq_end, w_active;

    // Next-state, datapath and next-output logic; every flash pin is registered
    // from these values so the clocks and their qualifiers are glitch-free.
    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_pcnt       = r_pcnt;
        w_sreg       = r_sreg;
        w_addr       = r_addr;
        w_last       = r_last;
        w_last_valid = r_last_valid;
        w_data       = r_data;
        w_dout       = r_dout;
        w_err        = r_err;

        case (r_state)
            S_LOAD:  w_npulse_m1 = PW'(ADDR_W - 1);
            S_SHIFT: w_npulse_m1 = PW'(31);
            default: w_npulse_m1 = '0;
        endcase

        w_active    = (r_state != S_IDLE) && (r_state != S_DONE);
        w_pulse_end = (r_cnt == LP_CNT_LAST);
        w_seq_end   = w_pulse_end && (r_pcnt == w_npulse_m1);

        if (w_active) begin
            w_cnt  = w_pulse_end ? '0 : r_cnt + CW'(1);
            w_pcnt = w_seq_end ? '0 : (w_pulse_end ? r_pcnt + PW'(1) : r_pcnt);
        end

        unique case (r_state)
            // DONE accepts a request exactly like IDLE since busy is already low there.
            S_IDLE, S_DONE: begin
                w_state = S_IDLE;
                if (rd) begin
                    w_addr = address;
                    w_cnt  = '0;
                    w_pcnt = '0;
                    if (32'(address) > LP_MAX) begin
                        w_state = S_DONE;
                        w_err   = 1'b1;
                        w_dout  = '1;
                    end else if (r_last_valid &&
                                 ((WADDR_W+1)'(address) == (WADDR_W+1)'(r_last) + (WADDR_W+1)'(1))) begin
                        w_state = S_INC;
                    end else begin
                        w_state = S_LOAD;
                        w_sreg  = ADDR_W'(address) + ADDR_W'(ADDR_OFS);
                    end
                end
            end
            S_LOAD: begin
                if (w_pulse_end) w_sreg = {r_sreg[ADDR_W-2:0], 1'b0};
                if (w_seq_end)   w_state = S_LATCH;
            end
            S_INC: begin
                if (w_seq_end) w_state = S_LATCH;
            end
            S_LATCH: begin
                if (w_seq_end) w_state = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_cnt == LP_CNT_SMP) w_data = {drdout, r_data[31:1]};
                if (w_seq_end) begin
                    w_state      = S_DONE;
                    w_dout       = r_data;
                    w_err        = 1'b0;
                    w_last       = r_addr;
                    w_last_valid = 1'b1;
                end
            end
            default: w_state = S_IDLE;
        endcase

        w_busy   = (w_state == S_LOAD) || (w_state == S_INC) ||
                   (w_state == S_LATCH) || (w_state == S_SHIFT);
        w_done   = (w_state == S_DONE);
        w_arclk  = ((w_state == S_LOAD) || (w_state == S_INC)) && (w_cnt >= LP_CNT_HI);
        w_arshft = (w_state != S_INC);
        w_ardin  = (w_state == S_LOAD) && w_sreg[ADDR_W-1];
        w_drclk  = ((w_state == S_LATCH) || (w_state == S_SHIFT)) && (w_cnt >= LP_CNT_HI);
        w_drshft = (w_state != S_LATCH);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_pcnt       <= '0;
            r_sreg       <= '0;
            r_addr       <= '0;
            r_last       <= '0;
            r_last_valid <= 1'b0;
            r_data       <= '0;
            r_dout       <= '0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_arclk      <= 1'b0;
            r_arshft     <= 1'b1;
            r_ardin      <= 1'b0;
            r_drclk      <= 1'b0;
            r_drshft     <= 1'b1;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_pcnt       <= w_pcnt;
            r_sreg       <= w_sreg;
            r_addr       <= w_addr;
            r_last       <= w_last;
            r_last_valid <= w_last_valid;
            r_data       <= w_data;
            r_dout       <= w_dout;
            r_err        <= w_err;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_arclk      <= w_arclk;
            r_arshft     <= w_arshft;
            r_ardin      <= w_ardin;
            r_drclk      <= w_drclk;
            r_drshft     <= w_drshft;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign dout   = r_dout;
    assign err    = r_err;
    assign arclk  = r_arclk;
    assign arshft = r_arshft;
    assign ardin  = r_ardin;
    assign drclk  = r_drclk;
    assign drshft = r_drshft;
    assign drdin  = 1'b0;

endmodule

// File: tb/tb_ufm_read_ctrl.sv
// Testbench for ufm_read_ctrl: behavioural UFM model plus transaction-level
// reference (latency, path choice, read data) driven by directed and random reads.
module tb_ufm_read_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd = 1'b0;
    logic [11:0] address = '0;
    logic        busy, done, err;
    logic [31:0] dout;
    logic        arclk, arshft, ardin, drclk, drshft, drdin, drdout;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    ufm_read_ctrl #(
        .CLK_DIV(4), .ADDR_W(23), .WADDR_W(12), .MAX_ADDR(3071), .ADDR_OFS(512)
    ) dut (
        .clock(clk), .reset(reset), .rd(rd), .address(address),
        .busy(busy), .done(done), .dout(dout), .err(err),
        .arclk(arclk), .arshft(arshft), .ardin(ardin),
        .drclk(drclk), .drshft(drshft), .drdin(drdin), .drdout(drdout)
    );

    always #5 clk = ~clk;

    // Flash array contents, indexed by word address.
    function automatic logic [31:0] fw(input logic [22:0] idx);
        return (32'(idx) * 32'h9E3779B1) ^ 32'hC0FFEE00;
    endfunction

    // Flash block model: address register and data register.
    logic [22:0] areg = '0;
    logic [22:0] lat_addr = '0;
    logic [31:0] dreg = '0;
    int unsigned n_ar_sh = 0, n_ar_inc = 0, n_dr_lat = 0, n_dr_sh = 0, n_done = 0;
    assign drdout = dreg[0];

    always @(posedge arclk) begin
        if (arshft) begin
            areg <= {areg[21:0], ardin};
            n_ar_sh++;
        end else begin
            areg <= areg + 23'd1;
            n_ar_inc++;
        end
    end

    always @(posedge drclk) begin
        if (!drshft) begin
            dreg     <= fw(areg - 23'd512);
            lat_addr <= areg;
            n_dr_lat++;
        end else begin
            dreg <= dreg >> 1;
            n_dr_sh++;
        end
    end

    always @(negedge clk) if (done) n_done++;

    // Reference state: last successfully read word.
    int unsigned m_last = 0;
    bit          m_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_dout"}, dout, 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_arclk"}, 32'(arclk), 0);
        chk({tag, "_arshft"}, 32'(arshft), 1);
        chk({tag, "_ardin"}, 32'(ardin), 0);
        chk({tag, "_drclk"}, 32'(drclk), 0);
        chk({tag, "_drshft"}, 32'(drshft), 1);
        chk({tag, "_drdin"}, 32'(drdin), 0);
    endtask

    // One read transaction; optionally pulses rd while busy to check it is ignored.
    task automatic do_read(input int unsigned a, input bit poke);
        bit          exp_err, exp_inc;
        int unsigned exp_lat, k;
        logic [31:0] exp_d;
        int unsigned sh0, inc0, lat0, dsh0, nd0;
        exp_err = (a > 3071);
        exp_inc = !exp_err && m_valid && (a == m_last + 1);
        exp_lat = exp_err ? 0 : 8 * (exp_inc ? 34 : 56);
        exp_d   = exp_err ? 32'hFFFFFFFF : fw(23'(a));

        @(negedge clk);
        sh0 = n_ar_sh; inc0 = n_ar_inc; lat0 = n_dr_lat; dsh0 = n_dr_sh; nd0 = n_done;
        rd = 1'b1;
        address = 12'(a);
        @(posedge clk);
        #1 rd = 1'b0;
        k = 0;
        @(negedge clk);
        if (!exp_err) chk("busy_start", 32'(busy), 1);
        while (!done && k < 2000) begin
            if (poke && k == 40) begin
                rd = 1'b1;
                address = 12'(a + 1);
            end else begin
                rd = 1'b0;
            end
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        rd = 1'b0;
        chk("latency", k, exp_lat);
        chk("done", 32'(done), 1);
        chk("err", 32'(err), 32'(exp_err));
        chk("dout", dout, exp_d);
        chk("busy_at_done", 32'(busy), 0);
        chk("ar_shift_pulses", n_ar_sh - sh0, (exp_err || exp_inc) ? 0 : 23);
        chk("ar_inc_pulses", n_ar_inc - inc0, exp_inc ? 1 : 0);
        chk("dr_latch_pulses", n_dr_lat - lat0, exp_err ? 0 : 1);
        chk("dr_shift_pulses", n_dr_sh - dsh0, exp_err ? 0 : 32);
        if (!exp_err) chk("flash_addr", 32'(lat_addr), a + 512);
        repeat (3) @(negedge clk);
        chk("done_count", n_done - nd0, 1);
        chk("done_pulse_end", 32'(done), 0);
        if (!exp_err) begin
            m_last  = a;
            m_valid = 1'b1;
        end
    endtask

    initial begin
        int unsigned a, r, nd0, ev0;

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_reset_state("por");
        reset = 1'b0;

        do_read(5, 1'b0);
        do_read(6, 1'b0);
        do_read(10, 1'b0);
        do_read(3072, 1'b0);
        do_read(3073, 1'b0);
        do_read(11, 1'b0);
        do_read(3071, 1'b0);
        do_read(0, 1'b0);

        // Idle reset clears outputs and the sequential-read history.
        repeat (5) @(negedge clk);
        ev0 = n_ar_sh + n_ar_inc + n_dr_lat + n_dr_sh;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_state("idle_rst");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_rst_edges", n_ar_sh + n_ar_inc + n_dr_lat + n_dr_sh, ev0);
        m_valid = 1'b0;
        do_read(1, 1'b0);

        // Reset 100 cycles into a LOAD aborts without done.
        @(negedge clk);
        nd0 = n_done;
        rd = 1'b1;
        address = 12'd20;
        @(posedge clk);
        #1 rd = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_arclk", 32'(arclk), 0);
        chk("abort_busy", 32'(busy), 0);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("abort_no_done", n_done - nd0, 0);
        m_valid = 1'b0;
        do_read(6, 1'b1);

        // Randomized reads mixing sequential, out-of-range and arbitrary addresses.
        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4 && m_valid && m_last < 3071) a = m_last + 1;
            else if (r < 6) a = $urandom_range(3072, 4095);
            else a = $urandom_range(0, 3071);
            do_read(a, (r == 9));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
